// File: rtl/sd_scaler_bank.sv
// Per-channel sigma-delta bit to signed level mapper, streamed out one channel per handshake.
// Define SD_SCALER_OFFSET_EN to add a per-channel offset table with a saturating adder.
module sd_scaler_bank #(
   parameter int  N = 4,
   parameter int  W = 16,
   parameter int  Q = 14,
   parameter real V = 1.0,
   localparam int CW = $clog2(N)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   input  logic [N-1:0]        in,
   input  logic                cfg_we,
   input  logic [CW-1:0]       cfg_ch,
   input  logic signed [W-1:0] cfg_pos,
   input  logic signed [W-1:0] cfg_neg,
`ifdef SD_SCALER_OFFSET_EN
   input  logic signed [W-1:0] cfg_off,
`endif
   output logic                out_valid,
   input  logic                out_ready,
   output logic signed [W-1:0] out_data,
   output logic [CW-1:0]       out_ch,
   output logic                out_last,
   output logic                overrun
);

   localparam int VP_I = $rtoi(V * (2.0 ** Q));
   localparam int VN_I = -VP_I;
   localparam logic signed [W-1:0] V_POS = W'(VP_I);
   localparam logic signed [W-1:0] V_NEG = W'(VN_I);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] SEND = 1'b1;
   localparam logic [CW-1:0] LAST_CH = CW'(N-1);

   logic [0:0]          state;
   logic [N-1:0]        frame;
   logic signed [W-1:0] pos_tbl [N];
   logic signed [W-1:0] neg_tbl [N];
   logic                cfg_hit;
   logic                is_last;
   logic                new_frame;
   logic                load;
   logic                ld_bit;
   logic [CW-1:0]       ld_ch;
   logic signed [W-1:0] ld_level;
   logic signed [W-1:0] ld_data;

   // cfg_ch fits in CW+1 bits alongside N, so the range check needs no sign games.
   assign cfg_hit = cfg_we && ({1'b0, cfg_ch} < (CW+1)'(N));

   // A new frame is taken from IDLE, or on the final handshake when a strobe coincides.
   always_comb begin
      is_last   = (out_ch == LAST_CH);
      new_frame = 1'b0;
      load      = 1'b0;
      if (state == IDLE) begin
         new_frame = in_valid;
         load      = in_valid;
      end else if (out_ready) begin
         new_frame = is_last && in_valid;
         load      = !is_last || in_valid;
      end
      ld_ch    = new_frame ? '0 : out_ch + CW'(1);
      ld_bit   = new_frame ? in[0] : frame[ld_ch];
      ld_level = ld_bit ? pos_tbl[ld_ch] : neg_tbl[ld_ch];
   end

`ifdef SD_SCALER_OFFSET_EN
   logic signed [W-1:0] off_tbl [N];
   logic signed [W:0]   sum;

   // Overflow shows up as disagreement between the two top bits of the widened sum.
   always_comb begin
      sum = {ld_level[W-1], ld_level} + {off_tbl[ld_ch][W-1], off_tbl[ld_ch]};
      if (sum[W] != sum[W-1])
         ld_data = sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      else
         ld_data = sum[W-1:0];
   end
`else
   assign ld_data = ld_level;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         frame     <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
         out_last  <= 1'b0;
         overrun   <= 1'b0;
         for (int k = 0; k < N; k++) begin
            pos_tbl[k] <= V_POS;
            neg_tbl[k] <= V_NEG;
`ifdef SD_SCALER_OFFSET_EN
            off_tbl[k] <= '0;
`endif
         end
      end else begin
         overrun <= (state == SEND) && in_valid && !(out_ready && is_last);
         // Table reads above use the pre-write values, so a same-cycle load sees the old level.
         if (cfg_hit) begin
            pos_tbl[cfg_ch] <= cfg_pos;
            neg_tbl[cfg_ch] <= cfg_neg;
`ifdef SD_SCALER_OFFSET_EN
            off_tbl[cfg_ch] <= cfg_off;
`endif
         end
         if (new_frame)
            frame <= in;
         if (load) begin
            out_data  <= ld_data;
            out_ch    <= ld_ch;
            out_last  <= (ld_ch == LAST_CH);
            out_valid <= 1'b1;
            state     <= SEND;
         end else if ((state == SEND) && out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
         end
      end
   end

endmodule

// File: tb/tb_sd_scaler_bank.sv
// Scoreboard bench for sd_scaler_bank: a frame-level model predicts words, overrun and valid per cycle.
`timescale 1ns/1ps
module tb_sd_scaler_bank;

   localparam int N   = 4;
   localparam int W   = 16;
   localparam int Q   = 14;
   localparam int CW  = $clog2(N);
   localparam int LVL = 1 << Q;

   logic                clk;
   logic                reset;
   logic                in_valid;
   logic [N-1:0]        in;
   logic                cfg_we;
   logic [CW-1:0]       cfg_ch;
   logic signed [W-1:0] cfg_pos;
   logic signed [W-1:0] cfg_neg;
   logic signed [W-1:0] cfg_off;
   logic                out_valid;
   logic                out_ready;
   logic signed [W-1:0] out_data;
   logic [CW-1:0]       out_ch;
   logic                out_last;
   logic                overrun;

   sd_scaler_bank #(.N(N), .W(W), .Q(Q), .V(1.0)) dut (
      .clk(clk),
      .reset(reset),
      .in_valid(in_valid),
      .in(in),
      .cfg_we(cfg_we),
      .cfg_ch(cfg_ch),
      .cfg_pos(cfg_pos),
      .cfg_neg(cfg_neg),
`ifdef SD_SCALER_OFFSET_EN
      .cfg_off(cfg_off),
`endif
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data),
      .out_ch(out_ch),
      .out_last(out_last),
      .overrun(overrun)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model state: level tables and words still owed by the current frame.
   int m_pos [N];
   int m_neg [N];
   int m_off [N];
   int pending;
   logic [W+CW:0] exp_q [$];
   logic [1:0]    cyc_q [$];
   logic          started;
   int            n_checks;
   int            n_fail;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [W+CW:0] exp_word(input int k, input logic b);
      int v;
      v = b ? m_pos[k] : m_neg[k];
`ifdef SD_SCALER_OFFSET_EN
      v = v + m_off[k];
      if (v > (1 << (W-1)) - 1) v = (1 << (W-1)) - 1;
      if (v < -(1 << (W-1)))    v = -(1 << (W-1));
`endif
      return {W'(v), CW'(k), (k == N-1)};
   endfunction

   // Drives one clock's worth of inputs and advances the model across the coming edge.
   task automatic cycle(input logic iv, input logic [N-1:0] bits, input logic rdy,
                        input logic we = 1'b0, input int wch = 0,
                        input logic [W-1:0] wpos = '0, input logic [W-1:0] wneg = '0,
                        input logic [W-1:0] woff = '0);
      logic hs, acc, drop;
      in_valid  = iv;
      in        = bits;
      out_ready = rdy;
      cfg_we    = we;
      cfg_ch    = CW'(wch);
      cfg_pos   = wpos;
      cfg_neg   = wneg;
      cfg_off   = woff;
      hs   = (pending > 0) && rdy;
      acc  = iv && ((pending == 0) || ((pending == 1) && rdy));
      drop = iv && !acc;
      if (hs) pending = pending - 1;
      if (acc) begin
         for (int k = 0; k < N; k++) exp_q.push_back(exp_word(k, bits[k]));
         pending = N;
      end
      if (we && (wch < N)) begin
         m_pos[wch] = $signed(wpos);
         m_neg[wch] = $signed(wneg);
`ifdef SD_SCALER_OFFSET_EN
         m_off[wch] = $signed(woff);
`endif
      end
      cyc_q.push_back({(pending > 0), drop});
      started = 1'b1;
      @(posedge clk);
      #2;
   endtask

   // Monitor: mid-cycle sampling, so out_ready seen here is the one the next edge uses.
   initial begin
      logic [1:0]    e;
      logic [W+CW:0] act;
      wait (started);
      @(posedge clk);
      forever begin
         @(negedge clk);
         if (cyc_q.size() != 0) begin
            e = cyc_q.pop_front();
            check("out_valid", 32'(out_valid), 32'(e[1]));
            check("overrun", 32'(overrun), 32'(e[0]));
         end
         if (out_valid) begin
            act = {out_data, out_ch, out_last};
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL spurious_word: got 0x%0h, expected no word (t=%0t)", act, $time);
            end else begin
               check("word{data,ch,last}", 32'(act), 32'(exp_q[0]));
               if (out_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      int guard;
      logic iv, rdy, we;
      n_checks = 0;
      n_fail   = 0;
      pending  = 0;
      started  = 1'b0;
      for (int k = 0; k < N; k++) begin
         m_pos[k] = LVL;
         m_neg[k] = -LVL;
         m_off[k] = 0;
      end
      reset     = 1'b1;
      in_valid  = 1'b1;
      in        = '1;
      out_ready = 1'b0;
      cfg_we    = 1'b0;
      cfg_ch    = '0;
      cfg_pos   = '0;
      cfg_neg   = '0;
      cfg_off   = '0;

      repeat (3) begin
         @(negedge clk);
         check("reset_out_valid", 32'(out_valid), 32'd0);
         check("reset_out_data", 32'(out_data), 32'd0);
         check("reset_out_ch", 32'(out_ch), 32'd0);
         check("reset_out_last", 32'(out_last), 32'd0);
         check("reset_overrun", 32'(overrun), 32'd0);
      end
      @(posedge clk);
      #2;
      reset = 1'b0;

      // Single frame with ready held high.
      cycle(1'b1, 4'b0101, 1'b1);
      repeat (5) cycle(1'b0, '0, 1'b1);

      // Backpressure on channel 1 for five cycles.
      cycle(1'b1, 4'b0110, 1'b1);
      cycle(1'b0, '0, 1'b1);
      repeat (5) cycle(1'b0, '0, 1'b0);
      repeat (5) cycle(1'b0, '0, 1'b1);

      // Dropped strobe at t+2, back-to-back strobe at t+4.
      cycle(1'b1, 4'b1010, 1'b1);
      cycle(1'b0, '0, 1'b1);
      cycle(1'b1, 4'b1111, 1'b1);
      cycle(1'b0, '0, 1'b1);
      cycle(1'b1, 4'b0011, 1'b1);
      repeat (5) cycle(1'b0, '0, 1'b1);

      // Level write to channel 2 in the very cycle channel 2 is loaded.
      cycle(1'b1, 4'b1111, 1'b1);
      cycle(1'b0, '0, 1'b1);
      cycle(1'b0, '0, 1'b1, 1'b1, 2, 16'h1000, W'(m_neg[2]), W'(m_off[2]));
      repeat (4) cycle(1'b0, '0, 1'b1);
      cycle(1'b1, 4'b1111, 1'b1);
      repeat (5) cycle(1'b0, '0, 1'b1);

`ifdef SD_SCALER_OFFSET_EN
      // Saturation at both rails.
      cycle(1'b0, '0, 1'b1, 1'b1, 0, 16'h7F00, 16'h8100, 16'h0200);
      cycle(1'b1, 4'b0001, 1'b1);
      repeat (4) cycle(1'b0, '0, 1'b1);
      cycle(1'b0, '0, 1'b1, 1'b1, 0, 16'h7F00, 16'h8100, 16'hFE00);
      cycle(1'b1, 4'b0000, 1'b1);
      repeat (5) cycle(1'b0, '0, 1'b1);
`endif

      // Random traffic; table writes only land while no frame is in flight.
      repeat (400) begin
         iv  = ($urandom_range(0, 5) == 0);
         rdy = ($urandom_range(0, 3) != 0);
         we  = (pending == 0) && !iv && ($urandom_range(0, 3) == 0);
         cycle(iv, N'($urandom), rdy, we, $urandom_range(0, N-1),
               W'($urandom), W'($urandom), W'($urandom));
      end

      guard = 0;
      while ((exp_q.size() != 0) && (guard < 50)) begin
         cycle(1'b0, '0, 1'b1);
         guard++;
      end
      repeat (3) cycle(1'b0, '0, 1'b1);
      @(negedge clk);
      #1;
      check("drain_words_left", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
